// File: rtl/dilated_window_gen.sv
// Row-stationary KxK sliding-window generator with runtime dilation, stride and row length.
// Optional window/stall counter ports are compiled in with DWG_WINDOW_CNT_EN.
module dilated_window_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int MAX_DIL_LOG2 = 2,
  parameter int ROW_LEN_W    = 10
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clear,
  input  logic                                      cfg_mode_i,
  input  logic [1:0]                                cfg_dil_log2_i,
  input  logic [1:0]                                cfg_stride_i,
  input  logic [ROW_LEN_W-1:0]                      cfg_row_len_i,
  input  logic                                      in_valid_i,
  output logic                                      in_ready_o,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]         in_data_i,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] out_data_o
`ifdef DWG_WINDOW_CNT_EN
  ,
  output logic [31:0]                               win_cnt_o,
  output logic [31:0]                               stall_cnt_o
`endif
);

  localparam int K     = KERNEL_SIZE;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = (K - 1) * (1 << MAX_DIL_LOG2) + 1;
  localparam logic [1:0] MAX_DIL = 2'(MAX_DIL_LOG2);

  logic                   mode_q;
  logic [1:0]             dil_q;
  logic [1:0]             stride_q;
  logic [ROW_LEN_W-1:0]   row_len_q;
  logic [ROW_LEN_W-1:0]   col_cnt;
  logic [1:0]             stride_cnt;
  logic                   out_valid_q;
  logic [K*K*DW-1:0]      out_data_q;

  // Tap 0 is the incoming beat; tap i is the sample accepted i beats earlier.
  logic [DW-1:0]          line [K][DEPTH-1];
  logic [DW-1:0]          tap  [K][DEPTH];
  logic [K*K*DW-1:0]      win;
  logic [ROW_LEN_W-1:0]   span;
  logic                   accept, produce, past_span, row_end;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never waits on ready, and a held window keeps its data until it transfers.
  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  assign accept    = in_valid_i && in_ready_o && !clear;
  assign span      = ROW_LEN_W'(K - 1) << dil_q;
  assign past_span = (col_cnt >= span);
  assign row_end   = (col_cnt == row_len_q - ROW_LEN_W'(1));
  assign produce   = mode_q || (past_span && (stride_cnt == 2'd0));

  always_comb begin
    for (int r = 0; r < K; r++) begin
      tap[r][0] = in_data_i[r*DW +: DW];
      for (int i = 1; i < DEPTH; i++) tap[r][i] = line[r][i-1];
    end
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (mode_q) begin
          win[(r*K+c)*DW +: DW] = tap[0][0];
        end else begin
          for (int dv = 0; dv <= MAX_DIL_LOG2; dv++) begin
            if (dil_q == 2'(dv)) win[(r*K+c)*DW +: DW] = tap[r][(K-1-c) << dv];
          end
        end
      end
    end
  end

  // Delay lines carry no reset; the column counter masks stale samples.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        line[r][0] <= in_data_i[r*DW +: DW];
        for (int i = 1; i < DEPTH - 1; i++) line[r][i] <= line[r][i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      dil_q       <= 2'd0;
      stride_q    <= 2'd0;
      row_len_q   <= ROW_LEN_W'(1);
      col_cnt     <= '0;
      stride_cnt  <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clear) begin
      mode_q      <= cfg_mode_i;
      dil_q       <= (cfg_dil_log2_i > MAX_DIL) ? MAX_DIL : cfg_dil_log2_i;
      stride_q    <= cfg_stride_i;
      row_len_q   <= cfg_row_len_i;
      col_cnt     <= '0;
      stride_cnt  <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        if (row_end) begin
          col_cnt    <= '0;
          stride_cnt <= 2'd0;
        end else begin
          col_cnt <= col_cnt + ROW_LEN_W'(1);
          if (past_span) stride_cnt <= (stride_cnt == stride_q) ? 2'd0 : stride_cnt + 2'd1;
        end
      end
      if (accept && produce) begin
        out_valid_q <= 1'b1;
        out_data_q  <= win;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef DWG_WINDOW_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else if (clear) begin
      win_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (out_valid_q && out_ready_i)  win_cnt_o   <= win_cnt_o + 32'd1;
      if (out_valid_q && !out_ready_i) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dilated_window_gen.sv
// Bench for dilated_window_gen: directed scenarios plus randomized rows against a row-history model.
module tb_dilated_window_gen;
  localparam int K  = 3;
  localparam int DW = 8;
  localparam int WW = K*K*DW;
  localparam int RLW = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            cfg_mode = 1'b0;
  logic [1:0]      cfg_dil = 2'd0;
  logic [1:0]      cfg_stride = 2'd0;
  logic [RLW-1:0]  cfg_row_len = RLW'(8);
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [K*DW-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [WW-1:0]   out_data;
`ifdef DWG_WINDOW_CNT_EN
  logic [31:0]     win_cnt, stall_cnt;
`endif

  dilated_window_gen #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .MAX_DIL_LOG2(2), .ROW_LEN_W(RLW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .cfg_mode_i(cfg_mode), .cfg_dil_log2_i(cfg_dil), .cfg_stride_i(cfg_stride), .cfg_row_len_i(cfg_row_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
`ifdef DWG_WINDOW_CNT_EN
    , .win_cnt_o(win_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_q[$];

  // Reference model state: configuration copy, column position and the current row's samples.
  bit            m_mode;
  int            m_dil, m_stride, m_row_len, m_col;
  logic [DW-1:0] hist [K][1024];
  int            hs_cnt, stall_m;
  bit            prev_stall;
  logic [WW-1:0] prev_data;
  bit            sender_done;

  task automatic model_beat();
    int d, span;
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++) hist[r][m_col] = in_data[r*DW +: DW];
    d = 1 << ((m_dil > 2) ? 2 : m_dil);
    span = (K - 1) * d;
    if (m_mode) begin
      for (int i = 0; i < K*K; i++) w[i*DW +: DW] = in_data[0 +: DW];
      exp_q.push_back(w);
    end else if (m_col >= span && ((m_col - span) % (m_stride + 1)) == 0) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) w[(r*K+c)*DW +: DW] = hist[r][m_col - (K-1-c)*d];
      exp_q.push_back(w);
    end
    m_col = (m_col == m_row_len - 1) ? 0 : m_col + 1;
  endtask

  // Scoreboard: observes each edge's inputs/outputs at the preceding negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_mode = 0; m_dil = 0; m_stride = 0; m_row_len = 1; m_col = 0;
      hs_cnt = 0; stall_m = 0; prev_stall = 0;
    end else begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL in_ready_rule: got %b valid %b ready %b", in_ready, out_valid, out_ready);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL hold: valid %b data %h required 1 %h", out_valid, out_data, prev_data);
        end
      end
`ifdef DWG_WINDOW_CNT_EN
      checks++;
      if (win_cnt !== 32'(hs_cnt) || stall_cnt !== 32'(stall_m)) begin
        errors++; $display("FAIL counters: win %0d stall %0d required %0d %0d", win_cnt, stall_cnt, hs_cnt, stall_m);
      end
`endif
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_window: got %h", out_data);
        end else begin
          logic [WW-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++; $display("FAIL window_data: got %h required %h", out_data, e);
          end
        end
      end
      if (out_valid && !out_ready) stall_m++;
      prev_stall = out_valid && !out_ready && !clear;
      prev_data  = out_data;
      if (clear) begin
        exp_q.delete();
        m_mode = cfg_mode; m_dil = int'(cfg_dil); m_stride = int'(cfg_stride);
        m_row_len = int'(cfg_row_len); m_col = 0;
        hs_cnt = 0; stall_m = 0;
      end else if (in_valid && in_ready) begin
        model_beat();
      end
    end
  end

  function automatic logic [WW-1:0] mk_win(int c0, int s);
    logic [WW-1:0] w;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) w[(r*K+c)*DW +: DW] = 8'(16*r + c0 + c*s);
    return w;
  endfunction

  function automatic logic [K*DW-1:0] row_data(int c);
    logic [K*DW-1:0] d;
    for (int r = 0; r < K; r++) d[r*DW +: DW] = 8'(16*r + c);
    return d;
  endfunction

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic configure(bit mode, int dil, int stride, int len);
    cfg_mode = mode; cfg_dil = 2'(dil); cfg_stride = 2'(stride); cfg_row_len = RLW'(len);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    got_q.delete();
  endtask

  task automatic send_beat(logic [K*DW-1:0] data, int max_gap);
    bit acc;
    int tries;
    in_valid = 1'b0;
    idle($urandom_range(0, max_gap));
    in_valid = 1'b1;
    in_data  = data;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 200) begin
      #1 acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++; $display("FAIL beat_timeout: accepted %b required 1", acc);
    end
  endtask

  task automatic check_drained(string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_drained: pending %0d required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_state: valid %b data %h ready %b required 0 0 1", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_basic();
    configure(0, 0, 0, 8);
    for (int c = 0; c < 8; c++) begin
      send_beat(row_data(c), 0);
      if (c == 1) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: valid %b required 0", out_valid); end
      end
      if (c == 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== mk_win(0, 1)) begin
          errors++; $display("FAIL basic_first: valid %b data %h required 1 %h", out_valid, out_data, mk_win(0, 1));
        end
      end
    end
    idle(3);
    checks++;
    if (got_q.size() != 6) begin errors++; $display("FAIL basic_count: got %0d required 6", got_q.size()); end
    check_drained("basic");
  endtask

  task automatic test_dilation();
    configure(0, 1, 0, 8);
    for (int c = 0; c < 8; c++) send_beat(row_data(c), 2);
    idle(3);
    checks++;
    if (got_q.size() != 4 || got_q[0] !== mk_win(0, 2) || got_q[3] !== mk_win(3, 2)) begin
      errors++; $display("FAIL dilation: count %0d first %h required 4 %h", got_q.size(), got_q[0], mk_win(0, 2));
    end
    check_drained("dilation");
  endtask

  task automatic test_stride();
    configure(0, 0, 1, 8);
    for (int c = 0; c < 8; c++) send_beat(row_data(c), 2);
    idle(3);
    checks++;
    if (got_q.size() != 3 || got_q[1] !== mk_win(2, 1) || got_q[2] !== mk_win(4, 1)) begin
      errors++; $display("FAIL stride: count %0d second %h required 3 %h", got_q.size(), got_q[1], mk_win(2, 1));
    end
    check_drained("stride");
  endtask

  task automatic test_back_to_back_backpressure();
    logic [WW-1:0] held;
    configure(0, 0, 0, 8);
    fork
      for (int c = 0; c < 8; c++) send_beat(row_data(c), 0);
      begin
        idle(4);
        out_ready = 1'b0;
        held = out_data;
        repeat (5) begin
          idle(1);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
            errors++; $display("FAIL stall: ready %b valid %b data %h required 0 1 %h", in_ready, out_valid, out_data, held);
          end
        end
        out_ready = 1'b1;
      end
    join
    idle(3);
    checks++;
    if (got_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d required 6", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 6; k++) begin
      checks++;
      if (got_q[k] !== mk_win(k, 1)) begin
        errors++; $display("FAIL bp_window%0d: got %h required %h", k, got_q[k], mk_win(k, 1));
      end
    end
    check_drained("bp");
  endtask

  task automatic test_pointwise();
    configure(1, 2, 3, 8);
    send_beat({8'h11, 8'h22, 8'h5A}, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {9{8'h5A}}) begin
      errors++; $display("FAIL pointwise_first: valid %b data %h required 1 %h", out_valid, out_data, {9{8'h5A}});
    end
    for (int i = 0; i < 11; i++) send_beat(24'($urandom), 2);
    idle(3);
    checks++;
    if (got_q.size() != 12) begin errors++; $display("FAIL pointwise_count: got %0d required 12", got_q.size()); end
    check_drained("pointwise");
  endtask

  task automatic test_clear();
    configure(0, 0, 0, 8);
    for (int c = 0; c < 3; c++) send_beat(row_data(c), 0);
    configure(0, 0, 0, 8);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b required 0", out_valid); end
`ifdef DWG_WINDOW_CNT_EN
    checks++;
    if (win_cnt !== 32'd0) begin errors++; $display("FAIL clear_win_cnt: got %0d required 0", win_cnt); end
`endif
    for (int c = 0; c < 3; c++) begin
      send_beat(row_data(64 + c), 0);
      checks++;
      if (c < 2 && out_valid !== 1'b0) begin
        errors++; $display("FAIL clear_fill%0d: valid %b required 0", c, out_valid);
      end else if (c == 2 && (out_valid !== 1'b1 || out_data !== mk_win(64, 1))) begin
        errors++; $display("FAIL clear_first: valid %b data %h required 1 %h", out_valid, out_data, mk_win(64, 1));
      end
    end
    idle(3);
    check_drained("clear");
  endtask

  task automatic test_reset_mid_row();
    configure(0, 0, 0, 8);
    for (int c = 0; c < 2; c++) send_beat(row_data(c), 0);
    out_ready = 1'b0;
    send_beat(row_data(2), 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL reset_mid_row: valid %b data %h required 0 0", out_valid, out_data);
    end
    out_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int len, beats;
      len = $urandom_range(1, 12);
      configure($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3), len);
      beats = 2*len + $urandom_range(0, len);
      sender_done = 0;
      fork
        begin
          for (int b = 0; b < beats; b++) send_beat(24'($urandom), 2);
          sender_done = 1;
        end
        while (!sender_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          idle(1);
        end
      join
      out_ready = 1'b1;
      idle(4);
      check_drained("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dilation();
    test_stride();
    test_back_to_back_backpressure();
    test_pointwise();
    test_clear();
    test_reset_mid_row();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: time %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
